kinase_valve_sequencer: RTL and testbench
=========================================

KINASE_VALVE_SEQUENCER -- requirements
Module: kinase_valve_sequencer

Interface
REQ-001 SHALL have parameter STEP_TICKS, default 1000, the number of clk cycles each pump phase is held (legal range 1..65535).
REQ-002 SHALL have parameter CNT_W, default 16, the width of pump-cycle and dwell counts.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset; asynchronous assertion, active-low.
REQ-005 SHALL have port cmd_valid, input, 1 bit, command offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit, command accepted when cmd_valid and cmd_ready are both high at a clk edge.
REQ-007 SHALL have port cmd_op, input, 2 bits: 0 SET_CTRL, 1 PUMP_A, 2 PUMP_B, 3 DWELL.
REQ-008 SHALL have port cmd_arg, input, 17 bits: SET_CTRL uses [12:0] for ctrl_a and [16:13] for ctrl_s; other ops use [CNT_W-1:0] as count N.
REQ-009 SHALL have port abort, input, 1 bit, terminates the active operation.
REQ-010 SHALL have ports pad_ctrl_a, output, 13 bits, and pad_ctrl_s, output, 4 bits: valve pressure lines (1 = pressurised/closed).
REQ-011 SHALL have ports pad_pump_a, output, 3 bits (peristaltic pump A), and pad_pump_b, output, 2 bits (pump B).
REQ-012 SHALL have ports busy, output, 1 bit; done, output, 1-cycle pulse; aborted, output, 1-cycle pulse.

Function
REQ-013 SHALL implement states IDLE, PUMP_A, PUMP_B, DWELL; cmd_ready = (state==IDLE) && !abort.
REQ-014 SHALL, on accepting SET_CTRL, register cmd_arg onto pad_ctrl_a/pad_ctrl_s at that edge, remain IDLE, and pulse done in the following cycle.
REQ-015 SHALL, on accepting PUMP_A with N>0, enter PUMP_A and drive phases 110,100,101,001,011,010 in order, each held exactly STEP_TICKS cycles, repeated N times (6*N*STEP_TICKS cycles total).
REQ-016 SHALL, on accepting PUMP_B with N>0, enter PUMP_B and drive phases 10,01, each held STEP_TICKS cycles, repeated N times.
REQ-017 SHALL, on accepting DWELL with N>0, enter DWELL for exactly N cycles with all outputs held.
REQ-018 SHALL, for PUMP_A/PUMP_B/DWELL with N=0, remain IDLE and pulse done the following cycle without changing any pad output.
REQ-019 SHALL hold idle pump patterns pad_pump_a=3'b111 and pad_pump_b=2'b11 whenever the respective pump is not running.
REQ-020 SHALL, at the end of the final phase, return to IDLE, restore the idle pump pattern and pulse done in the same cycle the state reads IDLE.
REQ-021 SHALL, when abort is high in a non-IDLE state, go to IDLE at the next edge, restore idle pump patterns, pulse aborted, not pulse done; pad_ctrl_a/pad_ctrl_s unchanged.
REQ-022 SHALL ignore abort in IDLE (no aborted pulse); abort with cmd_valid in IDLE accepts no command.
REQ-023 SHALL assert busy exactly when state != IDLE; all outputs SHALL be registered.
REQ-024 SHALL not wrap counters: count N=2^CNT_W-1 runs to completion.

Reset
REQ-025 SHALL, while rst_n low, force state IDLE, pad_ctrl_a=13'h1FFF, pad_ctrl_s=4'hF (all valves closed), pad_pump_a=3'b111, pad_pump_b=2'b11, busy/done/aborted=0.
REQ-026 SHALL, on reset mid-operation, discard the operation with no done or aborted pulse; cmd_ready high one cycle after rst_n deasserts.

Structure
REQ-027 SHALL place op encodings, state enum, PUMP_A/PUMP_B phase tables and idle patterns in package kinase_seq_pkg.
REQ-028 SHALL use one sub-module kinase_step_timer (STEP_TICKS down-counter with load and tick-expire outputs) shared by pump states.

Verification (STEP_TICKS=4)
REQ-029 SHALL cover: reset -> pad_ctrl_a=1FFF, pad_ctrl_s=F, pumps 111/11, cmd_ready=1 one cycle after release.
REQ-030 SHALL cover: SET_CTRL arg=17'h0_0A5 -> pad_ctrl_a=0A5, pad_ctrl_s=0 after accept edge, done next cycle, busy never high.
REQ-031 SHALL cover: PUMP_A N=2 -> 48 busy cycles, phase sequence 110..010 twice at 4 cycles each, then 111 with done.
REQ-032 SHALL cover: PUMP_B N=3 with abort asserted at busy cycle 10 -> IDLE next edge, pump_b=11, aborted pulse, no done.
REQ-033 SHALL cover: DWELL N=0 and PUMP_A N=0 -> done next cycle, no busy, outputs unchanged; DWELL N=5 -> busy exactly 5 cycles.
REQ-034 SHALL cover: rst_n low mid PUMP_A -> immediate idle patterns, no done/aborted, next command accepted normally.

Source files
------------

// File: rtl/kinase_seq_pkg.sv
// kinase_seq_pkg: op codes, states, pump phase tables and idle patterns for the valve sequencer
package kinase_seq_pkg;
  typedef enum logic [1:0] {OP_SET_CTRL, OP_PUMP_A, OP_PUMP_B, OP_DWELL} op_e;
  typedef enum logic [1:0] {S_IDLE, S_PUMP_A, S_PUMP_B, S_DWELL} state_e;
  localparam logic [2:0] PUMP_A_IDLE = 3'b111;
  localparam logic [1:0] PUMP_B_IDLE = 2'b11;
  localparam logic [2:0] PUMP_A_LAST = 3'd5;
  localparam logic [2:0] PUMP_B_LAST = 3'd1;
  localparam logic [5:0][2:0] PUMP_A_PHASES = {3'b010, 3'b011, 3'b001, 3'b101, 3'b100, 3'b110};
  localparam logic [1:0][1:0] PUMP_B_PHASES = {2'b01, 2'b10};
endpackage

// File: rtl/kinase_step_timer.sv
// kinase_step_timer: down-counter holding each pump phase for STEP_TICKS cycles
module kinase_step_timer #(
  parameter int STEP_TICKS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= 16'(STEP_TICKS - 1);
    else if (cnt != '0) cnt <= cnt - 16'd1;
  assign expire = cnt == '0;
endmodule

// File: rtl/kinase_valve_sequencer.sv
// kinase_valve_sequencer: command-driven valve/pump sequencer with abort and done pulses
module kinase_valve_sequencer import kinase_seq_pkg::*; #(
  parameter int STEP_TICKS = 1000,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [16:0] cmd_arg,
  input  logic        abort,
  output logic [12:0] pad_ctrl_a,
  output logic [3:0]  pad_ctrl_s,
  output logic [2:0]  pad_pump_a,
  output logic [1:0]  pad_pump_b,
  output logic        busy,
  output logic        done,
  output logic        aborted
);
  state_e state, state_d;
  logic [2:0] phase, phase_d;
  logic [CNT_W-1:0] rep, rep_d, n;
  logic [12:0] ctrl_a_d;
  logic [3:0] ctrl_s_d;
  logic [2:0] pump_a_d;
  logic [1:0] pump_b_d;
  logic done_d, aborted_d, load, expire, accept, last_step, last_phase;
  kinase_step_timer #(.STEP_TICKS(STEP_TICKS)) u_timer (.clk(clk), .rst_n(rst_n), .load(load), .expire(expire));
  assign cmd_ready = (state == S_IDLE) && !abort;
  assign busy = state != S_IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign n = cmd_arg[CNT_W-1:0];
  assign last_step = (state == S_DWELL) || expire;
  assign last_phase = state == S_PUMP_A ? phase == PUMP_A_LAST :
                      state == S_PUMP_B ? phase == PUMP_B_LAST : 1'b1;
  always_comb begin
    state_d = state;
    phase_d = phase;
    rep_d = rep;
    ctrl_a_d = pad_ctrl_a;
    ctrl_s_d = pad_ctrl_s;
    pump_a_d = pad_pump_a;
    pump_b_d = pad_pump_b;
    done_d = 1'b0;
    aborted_d = 1'b0;
    load = 1'b0;
    if (state == S_IDLE) begin
      if (accept && cmd_op == OP_SET_CTRL) begin
        ctrl_a_d = cmd_arg[12:0];
        ctrl_s_d = cmd_arg[16:13];
        done_d = 1'b1;
      end else if (accept && n == '0) begin
        done_d = 1'b1;
      end else if (accept) begin
        state_d = state_e'(cmd_op);
        rep_d = n;
        phase_d = '0;
        load = 1'b1;
        pump_a_d = cmd_op == OP_PUMP_A ? PUMP_A_PHASES[0] : pad_pump_a;
        pump_b_d = cmd_op == OP_PUMP_B ? PUMP_B_PHASES[0] : pad_pump_b;
      end
    end else if (abort || (last_step && last_phase && rep == CNT_W'(1))) begin
      state_d = S_IDLE;
      pump_a_d = PUMP_A_IDLE;
      pump_b_d = PUMP_B_IDLE;
      aborted_d = abort;
      done_d = !abort;
    end else if (last_step) begin
      // phase wrap closes one pump cycle; dwell counts every clock as a cycle
      phase_d = last_phase ? 3'd0 : phase + 3'd1;
      rep_d = last_phase ? rep - CNT_W'(1) : rep;
      load = 1'b1;
      pump_a_d = state == S_PUMP_A ? PUMP_A_PHASES[phase_d] : pad_pump_a;
      pump_b_d = state == S_PUMP_B ? PUMP_B_PHASES[phase_d[0]] : pad_pump_b;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      phase <= '0;
      rep <= '0;
      pad_ctrl_a <= 13'h1FFF;
      pad_ctrl_s <= 4'hF;
      pad_pump_a <= PUMP_A_IDLE;
      pad_pump_b <= PUMP_B_IDLE;
      done <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state <= state_d;
      phase <= phase_d;
      rep <= rep_d;
      pad_ctrl_a <= ctrl_a_d;
      pad_ctrl_s <= ctrl_s_d;
      pad_pump_a <= pump_a_d;
      pad_pump_b <= pump_b_d;
      done <= done_d;
      aborted <= aborted_d;
    end
endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// tb_kinase_valve_sequencer: directed self-checking bench at STEP_TICKS=4
module tb_kinase_valve_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, abort = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [16:0] cmd_arg = '0;
  logic cmd_ready, busy, done, aborted;
  logic [12:0] pad_ctrl_a;
  logic [3:0] pad_ctrl_s;
  logic [2:0] pad_pump_a;
  logic [1:0] pad_pump_b;
  int passed = 0, total = 0;
  logic [2:0] pa [6] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
  logic [1:0] pb [2] = '{2'b10, 2'b01};
  kinase_valve_sequencer #(.STEP_TICKS(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort),
    .pad_ctrl_a(pad_ctrl_a), .pad_ctrl_s(pad_ctrl_s),
    .pad_pump_a(pad_pump_a), .pad_pump_b(pad_pump_b),
    .busy(busy), .done(done), .aborted(aborted)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic idle_state(input string tag, input logic [12:0] ca, input logic [3:0] cs, input logic d, input logic a);
    check({tag, "_ctrl_a"}, 32'(pad_ctrl_a), 32'(ca));
    check({tag, "_ctrl_s"}, 32'(pad_ctrl_s), 32'(cs));
    check({tag, "_pump_a"}, 32'(pad_pump_a), 32'h7);
    check({tag, "_pump_b"}, 32'(pad_pump_b), 32'h3);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_aborted"}, 32'(aborted), 32'(a));
  endtask
  task automatic issue(input string tag, input logic [1:0] op, input logic [16:0] arg);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg = arg;
    #1 check({tag, "_ready"}, 32'(cmd_ready), 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    idle_state("rst", 13'h1FFF, 4'hF, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'h1);
    issue("set", 2'd0, 17'h0_00A5);
    idle_state("set", 13'h0A5, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("set_done_clr", 32'(done), 32'h0);
    issue("pa2", 2'd1, 17'd2);
    for (int i = 0; i < 48; i++) begin
      check($sformatf("pa2_busy%0d", i), 32'(busy), 32'h1);
      check($sformatf("pa2_ph%0d", i), 32'(pad_pump_a), 32'(pa[(i / 4) % 6]));
      check($sformatf("pa2_done%0d", i), 32'(done), 32'h0);
      @(negedge clk);
    end
    idle_state("pa2_end", 13'h0A5, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    issue("pb3", 2'd2, 17'd3);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("pb3_busy%0d", i), 32'(busy), 32'h1);
      check($sformatf("pb3_ph%0d", i), 32'(pad_pump_b), 32'(pb[(i / 4) % 2]));
      check($sformatf("pb3_pa%0d", i), 32'(pad_pump_a), 32'h7);
      if (i == 9) abort = 1'b1;
      else @(negedge clk);
    end
    #1 check("pb3_ready_abort", 32'(cmd_ready), 32'h0);
    @(negedge clk);
    abort = 1'b0;
    idle_state("pb3_abort", 13'h0A5, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    check("pb3_abort_clr", 32'(aborted), 32'h0);
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 2'd0;
    cmd_arg = 17'h1_FFFF;
    #1 check("idle_abort_ready", 32'(cmd_ready), 32'h0);
    @(negedge clk);
    abort = 1'b0;
    cmd_valid = 1'b0;
    idle_state("idle_abort", 13'h0A5, 4'h0, 1'b0, 1'b0);
    issue("dw0", 2'd3, 17'd0);
    idle_state("dw0", 13'h0A5, 4'h0, 1'b1, 1'b0);
    issue("pa0", 2'd1, 17'd0);
    idle_state("pa0", 13'h0A5, 4'h0, 1'b1, 1'b0);
    issue("dw5", 2'd3, 17'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("dw5_busy%0d", i), 32'(busy), 32'h1);
      @(negedge clk);
    end
    idle_state("dw5_end", 13'h0A5, 4'h0, 1'b1, 1'b0);
    issue("par", 2'd1, 17'd1);
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("par_busy", 32'(busy), 32'h1);
    check("par_ph", 32'(pad_pump_a), 32'(pa[1]));
    rst_n = 1'b0;
    #1 idle_state("par_rst", 13'h1FFF, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_state("par_rel", 13'h1FFF, 4'hF, 1'b0, 1'b0);
    check("par_rel_ready", 32'(cmd_ready), 32'h1);
    issue("pb1", 2'd2, 17'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pb1_ph%0d", i), 32'(pad_pump_b), 32'(pb[i / 4]));
      @(negedge clk);
    end
    idle_state("pb1_end", 13'h1FFF, 4'hF, 1'b1, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
